fulladder_bist_driver: RTL and testbench
========================================

// Module: fulladder_bist_driver
// PURPOSE
//   Self-checking stimulus driver and response checker for one 1-bit full
//   adder. On start, it applies all 8 {a,b,carryin} vectors in turn and holds
//   each vector for a settle window. It then samples sum/carryout, compares
//   them against the expected values, and reports pass/fail with error details.
//   The block sits on the adder's pins as their driver/checker, so the
//   structural and behavioural adders can be verified in hardware and in
//   simulation.
// PARAMETERS
//   SETTLE_CYCLES  4  clocks each vector is held before sampling; legal range 1..255
//   ERR_W          4  width of err_count; must be >= 4 so the count can reach 8
// PORTS
//   clk         in   1      single system clock, rising edge
//   reset       in   1      asynchronous, active-high reset
//   start       in   1      1-cycle pulse; begins a run from IDLE or DONE
//   abort       in   1      synchronous abort; returns to IDLE
//   a           out  1      adder operand a, driven to the DUT
//   b           out  1      adder operand b, driven to the DUT
//   carryin     out  1      adder carry-in, driven to the DUT
//   sum         in   1      sum returned by the DUT
//   carryout    out? no: in 1 carry-out returned by the DUT
//   busy        out  1      high while in APPLY or CHECK
//   done        out  1      high while in DONE
//   pass        out  1      valid when done=1; high if err_count == 0
//   err_count   out  ERR_W  number of mismatching vectors in the current run
//   fail_valid  out  1      high once any mismatch is recorded in this run
//   first_fail  out  3      {a,b,carryin} of the first mismatching vector
// BEHAVIOUR
//   Reset (asynchronous): every output goes to 0 and the FSM goes to IDLE.
//     Reset mid-run discards all progress.
//   Vector index v[2:0]: a=v[2], b=v[1], carryin=v[0]. Vectors run in order 0..7.
//   Expected values: sum = a^b^carryin; carryout = (a&b)|(a&carryin)|(b&carryin).
//   FSM states:
//     IDLE:  a/b/carryin = 0. start=1 -> APPLY with v=0, settle counter=0, and
//            err_count, fail_valid and first_fail cleared.
//     APPLY: drive v; the settle counter increments each clock. When the
//            counter reaches SETTLE_CYCLES-1 -> CHECK.
//     CHECK: exactly 1 cycle. Sample sum and carryout; a mismatch on either
//            bit counts as one error. On an error: err_count++, and if
//            fail_valid=0 then first_fail<=v and fail_valid<=1.
//            If v==7 -> DONE; otherwise v++, counter=0 -> APPLY.
//     DONE:  done=1, pass=(err_count==0), and results hold. The vector stays at
//            7. start=1 -> new run, following the IDLE start transition.
//   Timing: each vector takes SETTLE_CYCLES+1 clocks. done rises 8*(SETTLE_CYCLES+1)
//     edges after the edge that samples start.
//   Priority: abort > start. abort in any state -> IDLE with vector 0, busy=0 and
//     done=0; err_count and fail fields keep their values.
//   start while busy is ignored. pass is 0 whenever done=0.
//   err_count cannot overflow, because the maximum is 8 and ERR_W >= 4.
//   sum and carryout are sampled in CHECK only; values in any other state
//     are ignored.
// TESTING
//   T1: correct adder (combinational loopback), SETTLE_CYCLES=4, pulse start
//       -> done rises 40 edges later, pass=1, err_count=0, fail_valid=0.
//   T2: sum stuck at 0 -> err_count=4 (vectors 1,2,4,7), first_fail=3'b001,
//       pass=0.
//   T3: carryout inverted -> err_count=8, first_fail=3'b000, fail_valid=1,
//       pass=0.
//   T4: pulse start again 10 cycles into a run -> the run is not restarted,
//       and done still rises at edge 40 counted from the first start.
//   T5: assert reset asynchronously at cycle 17, then release and pulse start
//       -> all outputs are 0 during reset, and a full clean run then gives
//       pass=1.
//   T6: abort in CHECK of v=5, then start -> busy=0 the edge after abort, and
//       the new run begins at v=0 with err_count cleared.

Source files
------------

// File: rtl/fulladder_bist_driver.sv
// Built-in self-test driver/checker for a 1-bit full adder: walks all eight
// {a,b,carryin} vectors, holds each for a settle window, then grades the response.
module fulladder_bist_driver #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             carryin,
    input  logic             sum,
    input  logic             carryout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2:0]       first_fail
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] vec;
    logic [7:0] settle;
    logic       exp_sum;
    logic       exp_carry;
    logic       mismatch;

    // Operands come straight from the vector register, so the adder sees glitch-free inputs.
    assign {a, b, carryin} = vec;

    assign exp_sum   = vec[2] ^ vec[1] ^ vec[0];
    assign exp_carry = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    assign mismatch  = (sum != exp_sum) || (carryout != exp_carry);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vec        <= 3'd0;
            settle     <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= 3'd0;
        end else if (abort) begin
            // Results of the interrupted run stay visible for diagnosis.
            state  <= IDLE;
            vec    <= 3'd0;
            settle <= 8'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= APPLY;
                        vec        <= 3'd0;
                        settle     <= 8'd0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= 3'd0;
                    end
                end
                APPLY: begin
                    if (settle == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle <= settle + 8'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + ERR_W'(1);
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            first_fail <= vec;
                        end
                    end
                    if (vec == 3'd7) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // err_count has not absorbed this cycle's result yet.
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        state  <= APPLY;
                        vec    <= vec + 3'd1;
                        settle <= 8'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fulladder_bist_driver.sv
// Directed bench for fulladder_bist_driver with a behavioural adder in loopback
// and selectable faults (sum stuck at 0, carryout inverted).
module tb_fulladder_bist_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       a, b, carryin;
    logic       sum, carryout;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic       fail_valid;
    logic [2:0] first_fail;
    int         mode = 0;   // 0 good adder, 1 sum stuck-at-0, 2 carryout inverted

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    assign sum      = (mode == 1) ? 1'b0 : (a ^ b ^ carryin);
    assign carryout = (mode == 2) ? ~((a & b) | (a & carryin) | (b & carryin))
                                  : ((a & b) | (a & carryin) | (b & carryin));

    fulladder_bist_driver #(.SETTLE_CYCLES(4), .ERR_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .a(a), .b(b), .carryin(carryin), .sum(sum), .carryout(carryout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail(first_fail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"},  32'({a, b, carryin}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"},  32'(err_count), 32'd0);
        check({tag, "_fv"},   32'(fail_valid), 32'd0);
        check({tag, "_ff"},   32'(first_fail), 32'd0);
    endtask

    initial begin
        // Reset state
        step(2);
        check_all_zero("rst");
        reset = 1'b0;
        step(1);

        // T1: good adder, done exactly 40 edges after the start edge
        pulse_start();
        check("t1_busy0", 32'(busy), 32'd1);
        check("t1_vec0", 32'({a, b, carryin}), 32'd0);
        step(5);
        check("t1_vec1", 32'({a, b, carryin}), 32'd1);
        step(34);
        check("t1_done39", 32'(done), 32'd0);
        check("t1_pass39", 32'(pass), 32'd0);
        step(1);
        check("t1_done40", 32'(done), 32'd1);
        check("t1_busy40", 32'(busy), 32'd0);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        check("t1_fv", 32'(fail_valid), 32'd0);
        check("t1_vec7", 32'({a, b, carryin}), 32'd7);

        // T2: sum stuck at 0 -> vectors 1,2,4,7 fail
        mode = 1;
        pulse_start();
        step(40);
        check("t2_done", 32'(done), 32'd1);
        check("t2_err", 32'(err_count), 32'd4);
        check("t2_ff", 32'(first_fail), 32'd1);
        check("t2_fv", 32'(fail_valid), 32'd1);
        check("t2_pass", 32'(pass), 32'd0);

        // T3: carryout inverted -> every vector fails; restart clears results
        mode = 2;
        pulse_start();
        check("t3_errclr", 32'(err_count), 32'd0);
        check("t3_fvclr", 32'(fail_valid), 32'd0);
        check("t3_ffclr", 32'(first_fail), 32'd0);
        step(40);
        check("t3_err", 32'(err_count), 32'd8);
        check("t3_ff", 32'(first_fail), 32'd0);
        check("t3_fv", 32'(fail_valid), 32'd1);
        check("t3_pass", 32'(pass), 32'd0);

        // T4: start during a run is ignored
        mode = 0;
        pulse_start();
        step(9);
        pulse_start();
        check("t4_busy", 32'(busy), 32'd1);
        step(29);
        check("t4_done39", 32'(done), 32'd0);
        step(1);
        check("t4_done40", 32'(done), 32'd1);
        check("t4_pass", 32'(pass), 32'd1);

        // T5: asynchronous reset mid-run at cycle 17
        mode = 1;
        pulse_start();
        step(16);
        check("t5_errpre", 32'(err_count), 32'd2);
        check("t5_vecpre", 32'({a, b, carryin}), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t5_async");
        step(2);
        check_all_zero("t5_hold");
        reset = 1'b0;
        mode  = 0;
        step(1);
        pulse_start();
        step(40);
        check("t5_done", 32'(done), 32'd1);
        check("t5_pass", 32'(pass), 32'd1);

        // T6: abort in CHECK of v=5, results retained, then a fresh run
        mode = 1;
        pulse_start();
        step(29);
        check("t6_vec5", 32'({a, b, carryin}), 32'd5);
        abort = 1'b1;
        start = 1'b1;
        step(1);
        abort = 1'b0;
        start = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_vec", 32'({a, b, carryin}), 32'd0);
        check("t6_errkeep", 32'(err_count), 32'd3);
        check("t6_ffkeep", 32'(first_fail), 32'd1);
        check("t6_fvkeep", 32'(fail_valid), 32'd1);
        step(3);
        check("t6_idle", 32'(busy), 32'd0);
        mode = 0;
        pulse_start();
        check("t6_restart", 32'(busy), 32'd1);
        check("t6_errclr", 32'(err_count), 32'd0);
        check("t6_vecr", 32'({a, b, carryin}), 32'd0);
        step(40);
        check("t6_pass", 32'(pass), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
